// File: rtl/div_pkg.sv
// Shared definitions for the sequential RV64M divider: op codes, FSM encoding, width defaults.
package div_pkg;
    localparam int XLEN_DEF = 64;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        DIV_OP  = 2'b00,
        DIVU_OP = 2'b01,
        REM_OP  = 2'b10,
        REMU_OP = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    // op[0] clear selects the signed variants, op[1] set selects the remainder
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction
endpackage

// File: rtl/adder64b.sv
// Shared add/sub unit; with sub=1, c_o=1 means a >= b (no borrow).
module adder64b #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y,
    output logic         c_o
);
    assign {c_o, y} = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};
endmodule

// File: rtl/div64_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
module div64_seq
    import div_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    div_state_e      state, state_nx;
    logic [XLEN-1:0] r_q, q_q, b_q;
    logic [CW-1:0]   cnt;
    logic            rem_q, sign_q, sign_r;

    // Operand decode at start
    logic            ld_signed, ld_special;
    logic [XLEN-1:0] abs_a, abs_b, spec_res;

    always_comb begin
        ld_signed  = op_is_signed(op);
        abs_a      = (ld_signed && a[XLEN-1]) ? neg(a) : a;
        abs_b      = (ld_signed && b[XLEN-1]) ? neg(b) : b;
        ld_special = 1'b0;
        spec_res   = '0;
        if (b == '0) begin
            ld_special = 1'b1;
            spec_res   = op_is_rem(op) ? a : '1;
        end else if (ld_signed && a == MIN_NEG && b == '1) begin
            ld_special = 1'b1;
            spec_res   = op_is_rem(op) ? '0 : a;
        end
    end

    // Trial subtract: shifted partial remainder minus divisor
    logic [XLEN-1:0] s, d;
    logic            c_o, accept;

    assign s      = {r_q[XLEN-2:0], q_q[XLEN-1]};
    // A set R msb means the true shifted value is >= 2^XLEN, so it always exceeds B
    assign accept = c_o | r_q[XLEN-1];

    adder64b #(.W(XLEN)) u_sub (
        .a   (s),
        .b   (b_q),
        .sub (1'b1),
        .y   (d),
        .c_o (c_o)
    );

    logic [XLEN-1:0] quo_val, rem_val;
    assign quo_val = sign_q ? neg(q_q) : q_q;
    assign rem_val = sign_r ? neg(r_q) : r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = ld_special ? S_DONE : S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (cnt == CW'(XLEN-1)) state_nx = S_FIX;
            end
            S_FIX: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            q_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            rem_q  <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    if (ld_special) begin
                        result <= spec_res;
                    end else begin
                        rem_q  <= op_is_rem(op);
                        r_q    <= '0;
                        q_q    <= abs_a;
                        b_q    <= abs_b;
                        cnt    <= '0;
                        sign_q <= ld_signed & (a[XLEN-1] ^ b[XLEN-1]);
                        sign_r <= ld_signed & a[XLEN-1];
                    end
                end
                S_RUN: begin
                    r_q <= accept ? d : s;
                    q_q <= {q_q[XLEN-2:0], accept};
                    cnt <= cnt + CW'(1);
                end
                S_FIX: result <= rem_q ? rem_val : quo_val;
                default: ;
            endcase
        end
    end
endmodule
